// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the op encodings that the control unit drives on `op`, the FSM
// state encodings, and the default operand and counter widths.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the control/decode stage and muldiv_unit.
//   start   : one-cycle request pulse (control -> unit)
//   op      : operation select, see muldiv_pkg::op_e (control -> unit)
//   rs_val  : multiplicand / dividend (control -> unit)
//   rt_val  : multiplier / divisor (control -> unit)
//   busy    : operation in flight (unit -> control)
//   done    : one-cycle pulse, HI/LO hold the new result (unit -> control)
//   hi, lo  : architectural HI/LO registers (unit -> control)
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_core.sv
// Shared 2*WIDTH shift datapath for unsigned shift-add multiply and
// restoring divide, one bit per step.
//   clk, reset_n : clock, synchronous active-low reset (counter only)
//   i_load       : load i_a into the low half, i_b as multiplicand/divisor
//   i_step       : perform one iteration
//   i_mode       : 0 = multiply step, 1 = divide step
//   i_a, i_b     : unsigned operand magnitudes
//   o_acc        : accumulator; product, or {remainder, quotient}
//   o_last       : the current step is the final (WIDTH-th) one
module muldiv_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_mode,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_last
);
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_rem;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_div_nxt;

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right,
    // the carry landing in the top bit.
    assign w_add     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_add, r_acc[WIDTH-1:1]};

    // Divide: partial remainder shifted left by one needs WIDTH+1 bits.
    // When it is >= divisor the true difference fits in WIDTH bits, so a
    // modulo-2^WIDTH subtract is exact in the case that is kept.
    assign w_rem     = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge      = (w_rem >= {1'b0, r_b});
    assign w_diff    = w_rem[WIDTH-1:0] - r_b;
    assign w_div_nxt = {(w_ge ? w_diff : w_rem[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_acc <= {{WIDTH{1'b0}}, i_a};
            r_b   <= i_b;
        end else if (i_step) begin
            r_acc <= i_mode ? w_div_nxt : w_mul_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit (mult, multu, div, divu) holding the
// architectural HI/LO registers.
//   clk     : clock, all state changes on the rising edge
//   reset_n : synchronous active-low reset
//   bus     : muldiv_if slave (start/op/rs_val/rt_val in,
//             busy/done/hi/lo out)
// Signs are stripped on entry, muldiv_core works on magnitudes for WIDTH
// steps, and the FIX state restores signs and writes HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic     clk,
    input  logic     reset_n,
    muldiv_if.slave  bus
);
    state_e             r_state;
    state_e             w_next;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    op_e                r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_rs;

    logic               w_load;
    logic               w_step;
    logic               w_fix;
    logic               w_mode;
    logic               w_last;
    logic [2*WIDTH-1:0] w_acc;

    logic               w_is_signed;
    logic signed [WIDTH-1:0] w_rs_s;
    logic signed [WIDTH-1:0] w_rt_s;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_rt_zero;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rmd;
    logic [WIDTH-1:0]   w_hi_nxt;
    logic [WIDTH-1:0]   w_lo_nxt;

    function automatic logic [WIDTH-1:0] f_cneg_w(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] f_cneg_2w(input logic [2*WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Operand conditioning: mult and div are the signed ops (op[0] == 0).
    assign w_is_signed = ~bus.op[0];
    assign w_rs_s      = bus.rs_val;
    assign w_rt_s      = bus.rt_val;
    assign w_sign_a    = w_is_signed && (w_rs_s < 0);
    assign w_sign_b    = w_is_signed && (w_rt_s < 0);
    assign w_mag_a     = f_cneg_w(bus.rs_val, w_sign_a);
    assign w_mag_b     = f_cneg_w(bus.rt_val, w_sign_b);
    assign w_rt_zero   = (bus.rt_val == '0);

    muldiv_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_step  (w_step),
        .i_mode  (w_mode),
        .i_a     (w_mag_a),
        .i_b     (w_mag_b),
        .o_acc   (w_acc),
        .o_last  (w_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (!bus.op[1])     w_next = S_MUL;
                    else if (w_rt_zero) w_next = S_FIX;
                    else                w_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (w_last) w_next = S_FIX;
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output/control decode
    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_fix  = 1'b0;
        w_mode = 1'b0;
        case (r_state)
            S_IDLE:  w_load = bus.start;
            S_MUL:   w_step = 1'b1;
            S_DIV: begin
                w_step = 1'b1;
                w_mode = 1'b1;
            end
            S_FIX:   w_fix  = 1'b1;
            default: ;
        endcase
    end

    // Operand side information captured with the request
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_op     <= op_e'(bus.op);
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            r_dbz    <= bus.op[1] && w_rt_zero;
            r_rs     <= bus.rs_val;
        end
    end

    // Sign fix-up. Remainder follows the dividend; quotient and product are
    // negative when operand signs differ. 0x8000_0000 / -1 wraps naturally.
    assign w_prod = f_cneg_2w(w_acc, (r_op == OP_MULT) && (r_sign_a ^ r_sign_b));
    assign w_quo  = f_cneg_w(w_acc[WIDTH-1:0], (r_op == OP_DIV) && (r_sign_a ^ r_sign_b));
    assign w_rmd  = f_cneg_w(w_acc[2*WIDTH-1:WIDTH], (r_op == OP_DIV) && r_sign_a);

    always_comb begin
        w_hi_nxt = w_prod[2*WIDTH-1:WIDTH];
        w_lo_nxt = w_prod[WIDTH-1:0];
        if (r_dbz) begin
            w_hi_nxt = r_rs;
            w_lo_nxt = '1;
        end else if ((r_op == OP_DIV) || (r_op == OP_DIVU)) begin
            w_hi_nxt = w_rmd;
            w_lo_nxt = w_quo;
        end
    end

    // Registered handshake and HI/LO; busy tracks the state being entered so
    // it drops in the same cycle done rises.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= w_fix;
            if (w_fix) begin
                r_hi <= w_hi_nxt;
                r_lo <= w_lo_nxt;
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
